// File: rtl/card_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : card_read_sequencer
// Brief    : Steps the punch card ROM through rows 0..NUM_ROWS-1 and streams
//            each row as four 4-bit digits (MSB nibble first) over valid/ready.
//            Optional blank-nibble / blank-row skipping: CARD_BLANK_SKIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module card_read_sequencer #(
    parameter int         NUM_ROWS     = 15,
    parameter logic [3:0] BLANK_NIBBLE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  sel_req,
    input  logic        mask_req,
    output logic [1:0]  card_slt,
    output logic        mask,
    output logic [3:0]  card_addr,
    input  logic [15:0] card_in,
    output logic [3:0]  digit,
    output logic [3:0]  digit_row,
    output logic [1:0]  digit_col,
    output logic        digit_valid,
    input  logic        digit_ready,
    output logic [5:0]  digit_count,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef CARD_BLANK_SKIP_EN
    localparam logic c_skip_en = 1'b1;
`else
    localparam logic c_skip_en = 1'b0;
`endif

    localparam logic [3:0] c_last_row  = 4'(NUM_ROWS - 1);
    localparam logic [5:0] c_count_max = 6'd63;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_row;
    logic [1:0]  r_col;
    logic [1:0]  r_card_slt;
    logic        r_mask;
    logic [3:0]  r_card_addr;
    logic [5:0]  r_digit_count;
    logic        r_err;

    logic [3:0]  w_nibble;
    logic        w_skip;
    logic        w_end_of_card;
    logic        w_valid;
    logic        w_xfer;
    logic        w_advance;
    logic        w_illegal;
    logic        w_accept;

    always_comb begin
        w_nibble = r_row[15:12];
        case (r_col)
            2'd0:    w_nibble = r_row[15:12];
            2'd1:    w_nibble = r_row[11:8];
            2'd2:    w_nibble = r_row[7:4];
            default: w_nibble = r_row[3:0];
        endcase
    end

    // Skip terms collapse to zero when the blank-skip feature is compiled out.
    assign w_skip        = c_skip_en & (w_nibble == BLANK_NIBBLE);
    assign w_end_of_card = c_skip_en & (card_in == 16'hFFFF);

    assign w_valid   = (r_state == S_EMIT) & ~w_skip;
    assign w_xfer    = w_valid & digit_ready & ~abort;
    assign w_advance = (r_state == S_EMIT) & ~abort & (w_skip | digit_ready);

    // sel 0 with equation cards addresses a ROM bank that drives nothing.
    assign w_illegal = (r_state == S_IDLE) & start & ~abort &
                       (sel_req == 2'b00) & ~mask_req;
    assign w_accept  = (r_state == S_IDLE) & start & ~abort & ~w_illegal;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_state_nxt = w_end_of_card ? S_DONE : S_EMIT;
            end
            S_EMIT: begin
                if (w_advance && (r_col == 2'd3))
                    w_state_nxt = (r_card_addr == c_last_row) ? S_DONE : S_FETCH;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_row         <= 16'h0000;
            r_col         <= 2'd0;
            r_card_slt    <= 2'd0;
            r_mask        <= 1'b0;
            r_card_addr   <= 4'd0;
            r_digit_count <= 6'd0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_illegal;
            if (w_accept) begin
                r_card_slt    <= sel_req;
                r_mask        <= mask_req;
                r_card_addr   <= 4'd0;
                r_digit_count <= 6'd0;
            end
            if ((r_state == S_FETCH) && !abort) begin
                r_row <= card_in;
                r_col <= 2'd0;
            end
            if (w_advance) begin
                r_col <= r_col + 2'd1;
                if ((r_col == 2'd3) && (r_card_addr != c_last_row))
                    r_card_addr <= r_card_addr + 4'd1;
            end
            if (w_xfer && (r_digit_count != c_count_max))
                r_digit_count <= r_digit_count + 6'd1;
        end
    end

    assign card_slt    = r_card_slt;
    assign mask        = r_mask;
    assign card_addr   = r_card_addr;
    assign digit       = w_nibble;
    assign digit_row   = r_card_addr;
    assign digit_col   = r_col;
    assign digit_valid = w_valid;
    assign digit_count = r_digit_count;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_card_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_card_read_sequencer
// Brief    : Directed bench for card_read_sequencer with a digit scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_card_read_sequencer;

    localparam int NR = 15;

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] r;
        logic [1:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  sel_req = 2'd0;
    logic        mask_req = 1'b0;
    logic        digit_ready = 1'b1;
    logic [1:0]  card_slt;
    logic        mask;
    logic [3:0]  card_addr;
    logic [15:0] card_in;
    logic [3:0]  digit;
    logic [3:0]  digit_row;
    logic [1:0]  digit_col;
    logic        digit_valid;
    logic [5:0]  digit_count;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] rom [16];
    exp_t        sb [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          fail_cnt = 0;
    int          cyc = 0;
    int          done_seen = 0;

    assign card_in = rom[card_addr];

    always #5 clk = ~clk;

    card_read_sequencer #(.NUM_ROWS(NR), .BLANK_NIBBLE(4'hF)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sel_req(sel_req), .mask_req(mask_req),
        .card_slt(card_slt), .mask(mask), .card_addr(card_addr),
        .card_in(card_in),
        .digit(digit), .digit_row(digit_row), .digit_col(digit_col),
        .digit_valid(digit_valid), .digit_ready(digit_ready),
        .digit_count(digit_count), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: a handshake visible now completes at the coming edge.
    task automatic tick();
        exp_t e;
        if (digit_valid && digit_ready && !abort && !rst) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", {digit, digit_row, digit_col}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("digit_row_col", {digit, digit_row, digit_col}, e);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (done) done_seen++;
    endtask

    task automatic rom_2535();
        for (int r = 0; r < 16; r++) rom[r] = 16'hFFFF;
        rom[0] = 16'h2535;
    endtask

    task automatic rom_pattern();
        for (int r = 0; r < 16; r++) rom[r] = {4'h1, 4'(r), 4'h2, 4'h3};
    endtask

    // Reference model of one card read with digit_ready held high.
    task automatic load_expect(output int n_digits, output int n_cycles);
        logic [15:0] w;
        logic [3:0]  nib;
        sb.delete();
        n_digits = 0;
        n_cycles = 0;
        for (int r = 0; r < NR; r++) begin
            w = rom[r];
            n_cycles++;
`ifdef CARD_BLANK_SKIP_EN
            if (w == 16'hFFFF) break;
`endif
            for (int c = 0; c < 4; c++) begin
                nib = w[15-4*c -: 4];
                n_cycles++;
`ifdef CARD_BLANK_SKIP_EN
                if (nib == 4'hF) continue;
`endif
                sb.push_back({nib, 4'(r), 2'(c)});
                n_digits++;
            end
        end
        n_cycles++;
    endtask

    task automatic start_read(input logic [1:0] s, input logic m);
        sel_req = s;
        mask_req = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        sel_req = 2'd0;
        mask_req = 1'b0;
    endtask

    task automatic run_until_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk("done_timeout", done, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {card_slt, mask, card_addr, digit, digit_row, digit_col,
                  digit_valid, digit_count, busy, done, err}, 0);
    endtask

    initial begin
        int nd;
        int nc;
        int t0;
        int d0;
        int n;

        // Reset state
        rom_2535();
        @(negedge clk);
        tick();
        tick();
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        tick();
        chk_all_zero("idle_after_reset");

        // Illegal request
        start_read(2'd0, 1'b0);
        chk("illegal_err", err, 1);
        chk("illegal_busy", busy, 0);
        chk("illegal_addr", card_addr, 0);
        tick();
        chk("illegal_err_pulse", err, 0);
        chk("illegal_still_idle", busy, 0);

        // Normal read
        rom_2535();
        load_expect(nd, nc);
        d0 = done_seen;
        t0 = cyc;
        start_read(2'd1, 1'b0);
        chk("start_slt", card_slt, 1);
        chk("start_mask", mask, 0);
        chk("start_busy", busy, 1);
        chk("lat_fetch_no_valid", digit_valid, 0);
        tick();
        chk("lat_first_valid", digit_valid, 1);
        run_until_done(200);
        chk("normal_cycles", cyc - t0, nc);
        chk("normal_count", digit_count, nd);
        tick();
        chk("normal_done_pulse", done, 0);
        chk("normal_busy_clear", busy, 0);
        chk("normal_done_once", done_seen - d0, 1);
        chk("normal_sb_empty", sb.size(), 0);

        // Backpressure at row 3, col 2
        rom_pattern();
        load_expect(nd, nc);
        start_read(2'd2, 1'b1);
        n = 0;
        while (!(digit_valid && digit_row == 4'd3 && digit_col == 2'd2) && n < 40) begin
            tick();
            n++;
        end
        chk("bp_reach", {digit_valid, digit_row, digit_col}, {1'b1, 4'd3, 2'd2});
        digit_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {digit_valid, digit, digit_row, digit_col}, {1'b1, 4'h2, 4'd3, 2'd2});
            chk("bp_count", digit_count, 14);
        end
        digit_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_ignored_err", err, 0);
        chk("busy_start_ignored_slt", card_slt, 2);
        run_until_done(200);
        chk("bp_count_final", digit_count, nd);
        tick();
        chk("bp_sb_empty", sb.size(), 0);

        // Abort during row 7 FETCH
        rom_pattern();
        load_expect(nd, nc);
        d0 = done_seen;
        start_read(2'd1, 1'b1);
        n = 0;
        while (!(busy && !digit_valid && card_addr == 4'd7) && n < 60) begin
            tick();
            n++;
        end
        chk("abort_reach_fetch7", {busy, digit_valid, card_addr}, {1'b1, 1'b0, 4'd7});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
        chk("abort_busy", busy, 0);
        chk("abort_valid", digit_valid, 0);
        chk("abort_addr_held", card_addr, 7);
        chk("abort_count_held", digit_count, 28);
        tick();
        chk("abort_no_done", done_seen - d0, 0);

        // Restart after abort, then reset mid-EMIT
        load_expect(nd, nc);
        d0 = done_seen;
        start_read(2'd3, 1'b1);
        chk("restart_sel_mask_addr", {card_slt, mask, card_addr}, {2'd3, 1'b1, 4'd0});
        chk("restart_count", digit_count, 0);
        tick();
        tick();
        tick();
        chk("restart_row0", {digit_valid, digit_row, digit_col}, {1'b1, 4'd0, 2'd2});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk_all_zero("midread_reset");
        tick();
        tick();
        chk("midread_reset_idle", busy, 0);
        chk("midread_reset_no_done", done_seen - d0, 0);

        // Normal read after reset
        load_expect(nd, nc);
        d0 = done_seen;
        t0 = cyc;
        start_read(2'd1, 1'b0);
        run_until_done(200);
        chk("post_reset_cycles", cyc - t0, nc);
        chk("post_reset_count", digit_count, nd);
        tick();
        chk("post_reset_done_once", done_seen - d0, 1);

`ifdef CARD_BLANK_SKIP_EN
        // Blank nibble and blank row skipping
        for (int r = 0; r < 16; r++) rom[r] = 16'hFFFF;
        rom[0] = 16'h1F8F;
        load_expect(nd, nc);
        d0 = done_seen;
        start_read(2'd1, 1'b0);
        run_until_done(50);
        chk("skip_count", digit_count, 2);
        chk("skip_model_count", nd, 2);
        tick();
        chk("skip_done_once", done_seen - d0, 1);
        chk("skip_sb_empty", sb.size(), 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/card_read_sequencer.md
Name: card_read_sequencer

Overview:
- Sequences the punch card ROM for the base conversion datapath.
- On a start request it latches a card select and mask flag, then steps card_addr through rows 0..NUM_ROWS-1.
- Each 16-bit row is split into four 4-bit digits, MSB nibble first, and streamed downstream over a valid/ready handshake.
- Reports busy, done and illegal-select error; supports abort.

Parameters:
- NUM_ROWS, 15, rows per card; card_addr runs 0..NUM_ROWS-1 (max 16).
- BLANK_NIBBLE, 4'hF, nibble code meaning "no punch".

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a card read; sampled only in IDLE
- abort  in  1  terminate the current read; return to IDLE
- sel_req  in  2  requested card select
- mask_req  in  1  requested mask flag (1 = mask cards, 0 = equation cards)
- card_slt  out  2  registered card select to the ROM
- mask  out  1  registered mask flag to the ROM
- card_addr  out  4  registered row address to the ROM
- card_in  in  16  ROM row data (combinational from card_slt/mask/card_addr)
- digit  out  4  current digit
- digit_row  out  4  row of the current digit
- digit_col  out  2  nibble index, 0 = bits [15:12]
- digit_valid  out  1  digit/row/col are valid
- digit_ready  in  1  downstream accepts the digit
- digit_count  out  6  digits emitted since the last start
- busy  out  1  read in progress
- done  out  1  one-cycle pulse at normal end of card
- err  out  1  one-cycle pulse on illegal request

Behaviour:
- Reset: state IDLE; all outputs 0, including card_slt, mask, card_addr, digit*, digit_count, busy, done, err. Reset mid-read drops the read immediately; no done is generated.
- States: IDLE, FETCH, EMIT, DONE.
- IDLE, start=1 with sel_req=2'b00 and mask_req=0 (undriven ROM output): err=1 for one cycle, stay IDLE, outputs unchanged.
- IDLE, start=1 otherwise: register card_slt<=sel_req and mask<=mask_req; set card_addr<=0 and digit_count<=0; busy<=1; go to FETCH.
- start while busy is ignored. sel_req and mask_req are don't-care outside an accepted start.
- FETCH: capture card_in into the row register; col<=0; go to EMIT. The ROM therefore has one full cycle of settle time after each address change.
- EMIT: digit = row_reg[15-4*col -: 4]; digit_row = card_addr; digit_col = col; digit_valid = 1.
- A transfer occurs on digit_valid & digit_ready. On transfer, digit_count increments, then:
  - col<3: col++.
  - col==3 and card_addr<NUM_ROWS-1: card_addr++, go to FETCH.
  - col==3 and card_addr==NUM_ROWS-1: go to DONE.
- digit, digit_row and digit_col are held stable while digit_valid=1 and digit_ready=0.
- DONE: done=1 for one cycle, busy<=0, digit_valid=0; go to IDLE.
- Latency: start accepted at edge k; first digit_valid at edge k+2. Each row costs 1 FETCH cycle plus 4 EMIT handshakes, so minimum cycles per card = NUM_ROWS*5 + 1 (DONE).
- abort: has priority over everything except rst. In any non-IDLE state it forces IDLE next cycle with busy=0, digit_valid=0 and no done; card_addr and digit_count hold their values.
- abort and a transfer in the same cycle: abort wins, and digit_count does not increment.
- digit_count saturates at 63. With NUM_ROWS<=15 it cannot exceed 60.

Optional Feature:
- Macro: CARD_BLANK_SKIP_EN.
- Defined, FETCH: if card_in==16'hFFFF, go straight to DONE (end of card); that row emits no digits.
- Defined, EMIT: a nibble equal to BLANK_NIBBLE is skipped without asserting digit_valid. One cycle per skipped nibble; col/row advance as for a transfer; digit_count is not incremented.
- Not defined: every nibble of every row is emitted, including 4'hF, and all NUM_ROWS rows are read.

Test Plan:
- Reset: pulse rst mid-EMIT, then release -> all outputs 0, state IDLE; the next start behaves normally.
- Normal read (no macro): sel_req=1, mask_req=0, ROM row0=16'h2535, other rows 16'hFFFF, digit_ready=1.
  - First digit_valid 2 cycles after start; digits 2,5,3,5 then F x56.
  - digit_count=60; done pulses once; total 76 cycles from start to done.
- Backpressure: digit_ready low for 5 cycles during row 3, col 2 -> digit, digit_row=3 and digit_col=2 stay stable; no count change until ready returns.
- Illegal request: start with sel_req=0, mask_req=0 -> err=1 for exactly one cycle, busy stays 0, card_addr stays 0.
- Abort: abort during row 7 FETCH -> busy=0 next cycle, no done, card_addr=7 held; a following start with sel_req=3, mask_req=1 reads from row 0.
- With CARD_BLANK_SKIP_EN: row0=16'h1F8F, row1=16'hFFFF -> digits 1,8 only, digit_count=2, done pulses; row 1 emits nothing.
